// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: shared constants for the memory-mapped UART transmitter.
// Holds the register byte offsets inside the 16-byte window, the STATUS/CTRL
// bit positions, the TX state encoding and the reset bit-period divisor.
package mmio_uart_tx_pkg;

  // Register byte offsets (bus_addr[3:0] with the two low bits cleared)
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DIV    = 4'h8;
  localparam logic [3:0] OFF_CTRL   = 4'hC;

  // STATUS bit positions
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam logic [15:0] DEFAULT_DIV_C = 16'd868;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU load/store bus seen by a memory-mapped responder.
//   bus_re    - read strobe
//   bus_we    - byte-lane write enables
//   bus_addr  - byte address
//   bus_wdata - write data
//   bus_rdata - read data, combinational, 0 when the responder is not selected
interface mmio_uart_tx_if;
  logic        bus_re;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (output bus_re, bus_we, bus_addr, bus_wdata, input bus_rdata);
  modport slave  (input bus_re, bus_we, bus_addr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO for the UART transmit path.
//   clk, rst_n  - clock, asynchronous active-low reset (pointers/count only)
//   push, din   - write request and data; ignored when full unless popping
//   pop, dout   - read request; dout is the current head (show-ahead)
//   full, empty - occupancy flags
//   count       - number of stored entries
// A push and pop in the same cycle both take effect, even when full.
module uart_tx_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // When full, the simultaneous pop frees the slot being written.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - load/store responder port (mmio_uart_tx_if.slave)
//   uart_tx    - serial output, idle high
//   irq        - registered TX-done level interrupt
// Registers: 0x0 TXDATA (push), 0x4 STATUS, 0x8 DIV, 0xC CTRL.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic           clk,
  input  logic           rst_n,
  mmio_uart_tx_if.slave  bus,
  output logic           uart_tx,
  output logic           irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel;
  logic [3:0]    off;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [31:0]   rdata_c;

  logic [15:0]   div_q;
  logic [15:0]   div_eff;
  logic          en_q;
  logic          irq_en_q;
  logic          ovf_q;

  tx_state_t     state;
  tx_state_t     nxt;
  logic [15:0]   cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic [15:0]   act_div_q;
  logic          baud_last;
  logic          busy;

  logic          unused_bits;
  assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:16], bus.bus_we[3:2]};

  assign sel     = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
  assign off     = {bus.bus_addr[3:2], 2'b00};
  assign push    = sel && (off == OFF_TXDATA) && bus.bus_we[0];
  assign busy    = (state != S_IDLE);
  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
  assign baud_last = (cnt_q == act_div_q - 16'd1);

  uart_tx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.bus_wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Read mux returns zero when unselected so responders can be OR-combined.
  always_comb begin
    rdata_c = '0;
    if (sel && bus.bus_re) begin
      case (off)
        OFF_STATUS: begin
          rdata_c[ST_FULL]            = full;
          rdata_c[ST_EMPTY]           = empty;
          rdata_c[ST_BUSY]            = busy;
          rdata_c[ST_OVF]             = ovf_q;
          rdata_c[ST_CNT_LSB +: 4]    = 4'(count);
        end
        OFF_DIV:  rdata_c[15:0] = div_q;
        OFF_CTRL: begin
          rdata_c[CTRL_EN]     = en_q;
          rdata_c[CTRL_IRQ_EN] = irq_en_q;
        end
        default:  rdata_c = '0;
      endcase
    end
  end
  assign bus.bus_rdata = rdata_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= DEFAULT_DIV;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (sel && off == OFF_DIV) begin
        if (bus.bus_we[0]) div_q[7:0]  <= bus.bus_wdata[7:0];
        if (bus.bus_we[1]) div_q[15:8] <= bus.bus_wdata[15:8];
      end
      if (sel && off == OFF_CTRL && bus.bus_we[0]) begin
        en_q     <= bus.bus_wdata[CTRL_EN];
        irq_en_q <= bus.bus_wdata[CTRL_IRQ_EN];
      end
      // A dropped push outranks a same-cycle software clear.
      if (push && full && !pop)
        ovf_q <= 1'b1;
      else if (sel && off == OFF_STATUS && bus.bus_we[0] && bus.bus_wdata[ST_OVF])
        ovf_q <= 1'b0;
      irq <= irq_en_q && empty && !busy;
    end
  end

  // TX FSM: the head is popped on entry to START, from IDLE or straight from STOP.
  always_comb begin
    nxt = state;
    pop = 1'b0;
    case (state)
      S_IDLE: begin
        if (en_q && !empty) begin
          pop = 1'b1;
          nxt = S_START;
        end
      end
      S_START: if (baud_last) nxt = S_DATA;
      S_DATA:  if (baud_last && bit_idx_q == 3'd7) nxt = S_STOP;
      S_STOP: begin
        if (baud_last) begin
          if (en_q && !empty) begin
            pop = 1'b1;
            nxt = S_START;
          end else begin
            nxt = S_IDLE;
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
    end else begin
      state <= nxt;
      if (pop || state == S_IDLE) begin
        cnt_q     <= '0;
        bit_idx_q <= '0;
      end else if (baud_last) begin
        cnt_q <= '0;
        if (state == S_DATA) bit_idx_q <= bit_idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // The divisor is latched per frame so DIV writes only affect later frames.
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg_q   <= fifo_head;
      act_div_q <= div_eff;
    end else if (state == S_DATA && baud_last) begin
      shreg_q   <= shreg_q >> 1;
    end
  end

  // Driven straight from state so reset forces the line high immediately.
  always_comb begin
    case (state)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = shreg_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic uart_tx;
  logic irq;
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] A_TX   = 32'h1000_0000;
  localparam logic [31:0] A_ST   = 32'h1000_0004;
  localparam logic [31:0] A_DIV  = 32'h1000_0008;
  localparam logic [31:0] A_CTRL = 32'h1000_000C;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR   (32'h1000_0000),
    .FIFO_DEPTH  (4),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .uart_tx (uart_tx),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    bus.bus_addr  = a;
    bus.bus_wdata = d;
    bus.bus_we    = we;
    @(posedge clk);
    #1;
    bus.bus_we    = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.bus_addr = a;
    bus.bus_re   = 1'b1;
    #1;
    v = bus.bus_rdata;
    bus.bus_re   = 1'b0;
  endtask

  task automatic do_reset();
    bus.bus_re = 1'b0;
    bus.bus_we = 4'b0000;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // exp_lat >= 0: wait for the start bit and check how many cycles it took.
  // exp_lat <  0: the start bit must be on the line right now.
  task automatic frame_chk(input string tag, input logic [7:0] b, input int d, input int exp_lat);
    int n;
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    if (exp_lat >= 0) begin
      n = 0;
      while (uart_tx !== 1'b0 && n < 64) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk({tag, " latency"}, n, exp_lat);
    end
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < d; k++) begin
        chk($sformatf("%s bit%0d cyc%0d", tag, i, k), {31'b0, uart_tx}, {31'b0, bits[i]});
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    int          n;
    int          hi;

    bus.bus_re    = 1'b0;
    bus.bus_we    = 4'b0000;
    bus.bus_addr  = 32'h0;
    bus.bus_wdata = 32'h0;
    #2;

    // Reset state
    rst_n = 1'b0;
    #3;
    chk("rst tx", {31'b0, uart_tx}, 32'h1);
    chk("rst irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(A_ST, v);   chk("rst status", v, 32'h2);
    rd(A_DIV, v);  chk("rst div", v, 32'd868);
    rd(A_CTRL, v); chk("rst ctrl", v, 32'h0);
    rd(A_TX, v);   chk("txdata reads 0", v, 32'h0);
    rd(32'h2000_0004, v); chk("unselected read", v, 32'h0);
    bus.bus_addr = A_DIV;
    #1;
    chk("re low read", bus.bus_rdata, 32'h0);

    // Single byte A5 at DIV=4
    wr(A_DIV, 32'h0000_0004, 4'b0011);
    wr(A_CTRL, 32'h1, 4'b0001);
    wr(A_TX, 32'hFFFF_FFA5, 4'b0001);
    chk("single pre-start tx", {31'b0, uart_tx}, 32'h1);
    frame_chk("single", 8'hA5, 4, 1);
    chk("single idle tx", {31'b0, uart_tx}, 32'h1);
    rd(A_ST, v); chk("single status", v, 32'h2);

    // Back-to-back frames at DIV=2 with irq enabled
    wr(A_CTRL, 32'h0, 4'b0001);
    wr(A_DIV, 32'h0000_0002, 4'b0011);
    wr(A_TX, 32'h00, 4'b0001);
    wr(A_TX, 32'hFF, 4'b0001);
    rd(A_ST, v); chk("b2b queued status", v, 32'h20);
    wr(A_CTRL, 32'h3, 4'b0001);
    frame_chk("b2b0", 8'h00, 2, 1);
    chk("b2b irq mid", {31'b0, irq}, 32'h0);
    frame_chk("b2b1", 8'hFF, 2, -1);
    chk("b2b irq at idle entry", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    chk("b2b irq", {31'b0, irq}, 32'h1);

    // Overflow with enable cleared
    do_reset();
    for (int i = 0; i < 5; i++) wr(A_TX, 32'h10 + i, 4'b0001);
    rd(A_ST, v); chk("ovf status", v, 32'h49);
    wr(A_ST, 32'h8, 4'b0001);
    rd(A_ST, v); chk("ovf cleared", v, 32'h41);
    chk("ovf irq", {31'b0, irq}, 32'h0);

    // DIV write mid-frame only affects the next frame
    do_reset();
    wr(A_DIV, 32'h8, 4'b0011);
    wr(A_TX, 32'h3C, 4'b0001);
    wr(A_TX, 32'h81, 4'b0001);
    wr(A_CTRL, 32'h1, 4'b0001);
    fork
      frame_chk("divA", 8'h3C, 8, 1);
      begin
        repeat (20) @(posedge clk);
        #1;
        wr(A_DIV, 32'h2, 4'b0011);
      end
    join
    frame_chk("divB", 8'h81, 2, -1);
    chk("divB idle tx", {31'b0, uart_tx}, 32'h1);

    // Clearing enable mid-frame lets the frame finish, then stays idle
    do_reset();
    wr(A_DIV, 32'h8, 4'b0011);
    wr(A_TX, 32'h5A, 4'b0001);
    wr(A_TX, 32'h33, 4'b0001);
    wr(A_CTRL, 32'h1, 4'b0001);
    fork
      frame_chk("en", 8'h5A, 8, 1);
      begin
        repeat (30) @(posedge clk);
        #1;
        wr(A_CTRL, 32'h0, 4'b0001);
      end
    join
    hi = 0;
    repeat (30) begin
      if (uart_tx !== 1'b1) hi++;
      @(posedge clk);
      #1;
    end
    chk("en stays idle", hi, 0);
    rd(A_ST, v); chk("en status", v, 32'h10);

    // Asynchronous reset in the middle of DATA
    do_reset();
    wr(A_DIV, 32'h4, 4'b0011);
    wr(A_TX, 32'hF0, 4'b0001);
    wr(A_CTRL, 32'h1, 4'b0001);
    n = 0;
    while (uart_tx !== 1'b0 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("areset start seen", {31'b0, uart_tx}, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    chk("areset data bit1", {31'b0, uart_tx}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset tx immediate", {31'b0, uart_tx}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(A_ST, v); chk("areset status", v, 32'h2);
    hi = 0;
    repeat (60) begin
      if (uart_tx !== 1'b1) hi++;
      @(posedge clk);
      #1;
    end
    chk("areset no more bits", hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
